// File: rtl/serial_rr_arbiter_if.sv
// Shared-channel bundle between the requester FSMs (master) and the arbiter (slave).
interface serial_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] x_src;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       x_out;

    modport slave  (input  req, x_src, output grant, sel, busy, x_out);
    modport master (output req, x_src, input  grant, sel, busy, x_out);
endinterface

// File: rtl/serial_rr_arbiter.sv
// Four-way round-robin arbiter that multiplexes one serial bit stream onto a shared
// detector input, with bounded bursts and a mandatory idle cycle between owners.
module serial_rr_arbiter #(
    parameter int unsigned BURST = 4
) (
    input logic               clk,
    input logic               rst,
    serial_rr_arbiter_if.slave bus
);
    localparam logic [7:0] CNT_LOAD = 8'(BURST - 1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_grant, w_grant_nxt;
    logic [1:0] r_sel,   w_sel_nxt;
    logic [1:0] r_last,  w_last_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;

    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_found;

    // Search starts just after the previous grantee, so it ends up lowest priority.
    always_comb begin
        w_win   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && bus.req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SERVE;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_sel_nxt   = w_win;
                    w_last_nxt  = w_win;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            SERVE: begin
                if (!bus.req[r_sel] || r_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 4'b0000;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.grant = r_grant;
    assign bus.sel   = r_sel;
    assign bus.busy  = (r_state == SERVE);
    assign bus.x_out = (r_state == SERVE) ? bus.x_src[r_sel] : 1'b0;
endmodule
